mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_pkg.sv | 24 ++
 rtl/mem_stage_if.sv | 30 +++
 rtl/mem_wait_timer.sv | 49 ++++
 rtl/mem_stage.sv | 167 ++++++++++++++++
 tb/tb_mem_stage.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : mem_stage_pkg                                                |
// | Description : Shared pipeline definitions for the MEM stage: FSM state     |
// |               encoding, data width and default memory timeout.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package mem_stage_pkg;

  localparam int DATA_W          = 8;
  localparam int DEFAULT_TIMEOUT = 16;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_e;

  // Counter width able to hold TIMEOUT itself without wrapping.
  function automatic int wait_cnt_width(input int timeout);
    return (timeout < 2) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : mem_stage_if                                                 |
// | Description : Data-memory request/acknowledge handshake.                   |
// | Ports       : dmem_req, dmem_we, dmem_addr, dmem_wdata (stage -> memory)   |
// |               dmem_rdata, dmem_ack                     (memory -> stage)   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );

endinterface
`default_nettype wire

// File: rtl/mem_wait_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_wait_timer                                               |
// | Description : Counts cycles spent waiting for a memory acknowledge.        |
// | Ports       : clock, reset  - clock / synchronous active-high reset        |
// |               clear_i       - zero the count (entry to ACCESS)             |
// |               enable_i      - count one more waiting cycle                 |
// |               expired_o     - count has reached TIMEOUT-1                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mem_wait_timer
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clock,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CNT_W = wait_cnt_width(TIMEOUT);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign expired_o = (count_q == CNT_W'(TIMEOUT - 1));

  // Saturate at the expiry value so the count can never wrap.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && !expired_o) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_stage                                                    |
// | Description : Pipeline MEM stage. Resolves branches, performs data-memory  |
// |               accesses through a req/ack handshake with timeout, and holds |
// |               the MEM/WB pipeline register.                                |
// | Ports       : clock, reset         - clock / synchronous active-high reset |
// |               PC_jump_in, zero_in, branch_in -> pc_src, pc_target          |
// |               ALU_result_in, write_data_in, mem_* / reg_write_in controls  |
// |               stall                - hold request to upstream stages       |
// |               dmem                 - data-memory handshake (master side)   |
// |               read_data, alu_result_out, mem_to_reg_out, reg_write_out     |
// |               mem_error            - sticky timeout flag                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int PC_SIZE = 10,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [PC_SIZE-1:0]  PC_jump_in,
  input  logic                zero_in,
  input  logic [DATA_W-1:0]   ALU_result_in,
  input  logic [DATA_W-1:0]   write_data_in,
  input  logic                branch_in,
  input  logic                mem_read_in,
  input  logic                mem_write_in,
  input  logic                mem_to_reg_in,
  input  logic                reg_write_in,
  output logic                stall,
  output logic                pc_src,
  output logic [PC_SIZE-1:0]  pc_target,
  mem_stage_if.master         dmem,
  output logic [DATA_W-1:0]   read_data,
  output logic [DATA_W-1:0]   alu_result_out,
  output logic                mem_to_reg_out,
  output logic                reg_write_out,
  output logic                mem_error
);

  mem_state_e        state_q, state_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic              m2r_q, m2r_d;
  logic              rw_q, rw_d;
  logic              err_q, err_d;
  logic              timer_clear;
  logic              timer_en;
  logic              timer_expired;
  logic              access;

  assign pc_src    = branch_in & zero_in;
  assign pc_target = PC_jump_in;
  assign access    = mem_read_in | mem_write_in;

  assign dmem.dmem_req   = (state_q == ACCESS);
  assign dmem.dmem_we    = we_q & (state_q == ACCESS);
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;

  assign read_data      = rdata_q;
  assign alu_result_out = alu_q;
  assign mem_to_reg_out = m2r_q;
  assign reg_write_out  = rw_q;
  assign mem_error      = err_q;

  mem_wait_timer #(
    .TIMEOUT   (TIMEOUT)
  ) u_wait_timer (
    .clock     (clock),
    .reset     (reset),
    .clear_i   (timer_clear),
    .enable_i  (timer_en),
    .expired_o (timer_expired)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    rdata_d     = rdata_q;
    alu_d       = alu_q;
    m2r_d       = m2r_q;
    rw_d        = rw_q;
    err_d       = err_q;
    stall       = 1'b0;
    timer_clear = 1'b0;
    timer_en    = 1'b0;

    case (state_q)
      IDLE: begin
        if (access) begin
          // Capture the request; a set write bit wins over a set read bit.
          stall       = 1'b1;
          addr_d      = ALU_result_in;
          wdata_d     = write_data_in;
          we_d        = mem_write_in;
          timer_clear = 1'b1;
          m2r_d       = 1'b0;
          rw_d        = 1'b0;
          state_d     = ACCESS;
        end else begin
          rdata_d = '0;
          alu_d   = ALU_result_in;
          m2r_d   = mem_to_reg_in;
          rw_d    = reg_write_in;
        end
      end
      ACCESS: begin
        if (dmem.dmem_ack) begin
          rdata_d = we_q ? '0 : dmem.dmem_rdata;
          alu_d   = addr_q;
          m2r_d   = mem_to_reg_in;
          rw_d    = reg_write_in;
          state_d = IDLE;
        end else if (timer_expired) begin
          // Give up: release upstream this cycle and flag the error.
          err_d   = 1'b1;
          m2r_d   = 1'b0;
          rw_d    = 1'b0;
          state_d = IDLE;
        end else begin
          stall    = 1'b1;
          timer_en = 1'b1;
          m2r_d    = 1'b0;
          rw_d     = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      alu_q   <= '0;
      m2r_q   <= 1'b0;
      rw_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      alu_q   <= alu_d;
      m2r_q   <= m2r_d;
      rw_q    <= rw_d;
      err_q   <= err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mem_stage                                                 |
// | Description : Self-checking bench for mem_stage. Each operation is         |
// |               predicted at transaction level: ALU ops complete in one      |
// |               cycle, accesses stall until ack or the timeout window ends.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int PC_SIZE = 10;
  localparam int TIMEOUT = 16;

  logic               clock = 1'b0;
  logic               reset;
  logic [PC_SIZE-1:0] PC_jump_in;
  logic               zero_in;
  logic [7:0]         ALU_result_in;
  logic [7:0]         write_data_in;
  logic               branch_in;
  logic               mem_read_in;
  logic               mem_write_in;
  logic               mem_to_reg_in;
  logic               reg_write_in;
  logic               stall;
  logic               pc_src;
  logic [PC_SIZE-1:0] pc_target;
  logic [7:0]         read_data;
  logic [7:0]         alu_result_out;
  logic               mem_to_reg_out;
  logic               reg_write_out;
  logic               mem_error;

  mem_stage_if dmem_bus ();

  mem_stage #(
    .PC_SIZE        (PC_SIZE),
    .TIMEOUT        (TIMEOUT)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .PC_jump_in     (PC_jump_in),
    .zero_in        (zero_in),
    .ALU_result_in  (ALU_result_in),
    .write_data_in  (write_data_in),
    .branch_in      (branch_in),
    .mem_read_in    (mem_read_in),
    .mem_write_in   (mem_write_in),
    .mem_to_reg_in  (mem_to_reg_in),
    .reg_write_in   (reg_write_in),
    .stall          (stall),
    .pc_src         (pc_src),
    .pc_target      (pc_target),
    .dmem           (dmem_bus),
    .read_data      (read_data),
    .alu_result_out (alu_result_out),
    .mem_to_reg_out (mem_to_reg_out),
    .reg_write_out  (reg_write_out),
    .mem_error      (mem_error)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  bit err_model = 1'b0;   // expected sticky error flag

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    mem_read_in   = 1'b0;
    mem_write_in  = 1'b0;
    mem_to_reg_in = 1'b0;
    reg_write_in  = 1'b0;
    ALU_result_in = '0;
    write_data_in = '0;
    branch_in     = 1'b0;
    zero_in       = 1'b0;
    PC_jump_in    = '0;
    dmem_bus.dmem_ack   = 1'b0;
    dmem_bus.dmem_rdata = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"},   dmem_bus.dmem_req,   0);
    check({tag, "_we"},    dmem_bus.dmem_we,    0);
    check({tag, "_addr"},  dmem_bus.dmem_addr,  0);
    check({tag, "_wdata"}, dmem_bus.dmem_wdata, 0);
    check({tag, "_rdata"}, read_data,      0);
    check({tag, "_alu"},   alu_result_out, 0);
    check({tag, "_m2r"},   mem_to_reg_out, 0);
    check({tag, "_rw"},    reg_write_out,  0);
    check({tag, "_err"},   mem_error,      0);
    check({tag, "_stall"}, stall,          0);
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    err_model = 1'b0;
    check_all_zero("reset");
  endtask

  // One pipeline operation. ack_dly = number of ACCESS cycles without ack
  // before ack arrives; ack_dly >= TIMEOUT means the memory never answers.
  task automatic do_op(input bit rd, input bit wr, input logic [7:0] addr,
                       input logic [7:0] wd, input logic [7:0] rdat,
                       input bit m2r, input bit rw, input int ack_dly);
    bit acc;
    bit ack;
    bit last;
    acc = rd | wr;
    mem_read_in   = rd;
    mem_write_in  = wr;
    ALU_result_in = addr;
    write_data_in = wd;
    mem_to_reg_in = m2r;
    reg_write_in  = rw;
    branch_in     = 1'($urandom);
    zero_in       = 1'($urandom);
    PC_jump_in    = PC_SIZE'($urandom);
    // A stray ack while idle must be ignored.
    dmem_bus.dmem_ack   = acc ? 1'b0 : 1'($urandom);
    dmem_bus.dmem_rdata = 8'($urandom);
    #1;
    check("pc_src",    pc_src,    branch_in & zero_in);
    check("pc_target", pc_target, PC_jump_in);
    check("req_idle",  dmem_bus.dmem_req, 0);
    check("stall_issue", stall, acc);
    tick();
    dmem_bus.dmem_ack = 1'b0;
    if (!acc) begin
      check("alu_out",   alu_result_out, addr);
      check("rw_out",    reg_write_out,  rw);
      check("m2r_out",   mem_to_reg_out, m2r);
      check("rdata_alu", read_data,      0);
      check("err_alu",   mem_error,      err_model);
      return;
    end
    check("bubble_rw",  reg_write_out,  0);
    check("bubble_m2r", mem_to_reg_out, 0);
    for (int c = 0; c < TIMEOUT; c++) begin
      ack  = (c == ack_dly);
      last = ack || (c == TIMEOUT - 1);
      dmem_bus.dmem_ack   = ack;
      dmem_bus.dmem_rdata = ack ? rdat : 8'($urandom);
      #1;
      check("req_acc",   dmem_bus.dmem_req,   1);
      check("addr_acc",  dmem_bus.dmem_addr,  addr);
      check("wdata_acc", dmem_bus.dmem_wdata, wd);
      check("we_acc",    dmem_bus.dmem_we,    wr);
      check("stall_acc", stall, !last);
      tick();
      dmem_bus.dmem_ack = 1'b0;
      if (ack) begin
        check("rdata_done", read_data,      wr ? 8'h00 : rdat);
        check("alu_done",   alu_result_out, addr);
        check("m2r_done",   mem_to_reg_out, m2r);
        check("rw_done",    reg_write_out,  rw);
      end else begin
        if (c == TIMEOUT - 1) err_model = 1'b1;
        check("wait_rw",  reg_write_out,  0);
        check("wait_m2r", mem_to_reg_out, 0);
      end
      check("err_acc", mem_error, err_model);
      if (last) break;
    end
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check_all_zero("por");

    // ALU op, load with immediate ack, store with 3-cycle ack delay.
    do_op(1'b0, 1'b0, 8'h2A, 8'h00, 8'h00, 1'b0, 1'b1, 0);
    do_op(1'b1, 1'b0, 8'h10, 8'h00, 8'h5C, 1'b1, 1'b1, 0);
    do_op(1'b0, 1'b1, 8'h20, 8'hA5, 8'h77, 1'b0, 1'b0, 3);
    // Both bits set: treated as a write, read_data loads 0.
    do_op(1'b1, 1'b1, 8'h44, 8'h19, 8'hEE, 1'b1, 1'b1, 1);

    // Timeout, then error must persist across later operations.
    do_op(1'b1, 1'b0, 8'h33, 8'h00, 8'h00, 1'b1, 1'b1, TIMEOUT + 4);
    do_op(1'b0, 1'b0, 8'h55, 8'h00, 8'h00, 1'b0, 1'b1, 0);
    check("err_sticky", mem_error, 1);

    // Branch resolution.
    branch_in = 1'b1; zero_in = 1'b1; PC_jump_in = 10'h3F0;
    #1;
    check("br_taken",  pc_src,    1);
    check("br_target", pc_target, 10'h3F0);
    zero_in = 1'b0;
    #1;
    check("br_not_taken", pc_src, 0);
    clear_inputs();

    // Reset on the second ACCESS cycle abandons the transaction.
    mem_read_in = 1'b1; ALU_result_in = 8'h66; reg_write_in = 1'b1; mem_to_reg_in = 1'b1;
    tick();
    #1;
    check("mid_req1", dmem_bus.dmem_req, 1);
    tick();
    check("mid_req2", dmem_bus.dmem_req, 1);
    do_reset();
    do_op(1'b0, 1'b0, 8'h2A, 8'h00, 8'h00, 1'b0, 1'b1, 0);

    // Randomized traffic.
    for (int i = 0; i < 150; i++) begin
      bit rd;
      bit wr;
      int dly;
      rd = 1'($urandom);
      wr = ($urandom_range(0, 2) == 0);
      dly = ($urandom_range(0, 9) == 0) ? TIMEOUT + int'($urandom_range(0, 3))
                                        : int'($urandom_range(0, 5));
      do_op(rd, wr, 8'($urandom), 8'($urandom), 8'($urandom),
            1'($urandom), 1'($urandom), dly);
      if (err_model && $urandom_range(0, 2) == 0) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
